// File: rtl/hps_cmd_pkg.sv
// Shared constants for the HPS command sequencer: register map, STATUS/CTRL
// bit positions, FSM encoding and the STATUS word packer.
package hps_cmd_pkg;

    localparam logic [1:0] ADDR_CMD    = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_LAST   = 2'd3;

    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_TIMEOUT = 4;
    localparam int ST_CNT_LSB = 8;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_FLUSH  = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ISSUE = 1'b1;

    function automatic logic [31:0] pack_status(
        input logic       busy,
        input logic       full,
        input logic       empty,
        input logic       ovf,
        input logic       tmo,
        input logic [4:0] cnt
    );
        logic [31:0] w;
        w                           = '0;
        w[ST_BUSY]                  = busy;
        w[ST_FULL]                  = full;
        w[ST_EMPTY]                 = empty;
        w[ST_OVF]                   = ovf;
        w[ST_TIMEOUT]               = tmo;
        w[ST_CNT_LSB+4:ST_CNT_LSB]  = cnt;
        return w;
    endfunction

endpackage

// File: rtl/hps_cmd_fifo.sv
// Synchronous FIFO with one-cycle flush; pointers carry an extra wrap bit so
// full/empty and count (0..DEPTH) fall out of a pointer compare.
module hps_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    // A push into a full FIFO is still taken when the head leaves in the same cycle.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/hps_cmd_sequencer.sv
// Avalon-MM command sequencer: buffers HPS command words and issues them over
// valid/ready. Optional handshake watchdog: define HPS_CMD_SEQ_TIMEOUT_EN.
module hps_cmd_sequencer
    import hps_cmd_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        read,
    output logic [31:0] readdata,
    output logic [31:0] cmd_data,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        irq,
    output logic [0:0]  dbg_state_o
);

    localparam int AW = $clog2(DEPTH);

    // Downstream handshake: a word transfers on a rising edge where cmd_valid
    // and cmd_ready are both 1; cmd_data is stable while valid && !ready.

    logic [0:0]  state_q, state_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [31:0] cmd_data_q, cmd_data_d;
    logic [31:0] last_q, last_d;
    logic [31:0] readdata_q, readdata_d;
    logic        enable_q, enable_d;
    logic        irq_en_q, irq_en_d;
    logic        ovf_q, ovf_d;
    logic        timeout_q;
    logic        timeout_set;

    logic        cmd_wr, status_wr, ctrl_wr;
    logic        flush;
    logic        fifo_pop;
    logic        can_issue;
    logic [31:0] fifo_rdata;
    logic        fifo_full, fifo_empty;
    logic [AW:0] fifo_count;
    logic [4:0]  count5;

    assign cmd_wr    = write && (address == ADDR_CMD);
    assign status_wr = write && (address == ADDR_STATUS);
    assign ctrl_wr   = write && (address == ADDR_CTRL);
    assign flush     = ctrl_wr && writedata[CTRL_FLUSH];
    assign can_issue = enable_q && !fifo_empty && !flush;
    assign count5    = 5'(fifo_count);

    hps_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (cmd_wr),
        .wdata   (writedata),
        .pop     (fifo_pop),
        .flush   (flush),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

`ifdef HPS_CMD_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          tmo_hit;
    logic          tmo_q, tmo_d;

    assign tmo_hit   = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    assign tmo_cnt_d = (state_q == S_ISSUE && !cmd_ready && !tmo_hit) ?
                       tmo_cnt_q + 1'b1 : '0;
    assign tmo_d     = timeout_set ||
                       (tmo_q && !(status_wr && writedata[ST_TIMEOUT]));
    assign timeout_q = tmo_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_q     <= tmo_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout_q          = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cmd_valid_d = cmd_valid_q;
        cmd_data_d  = cmd_data_q;
        last_d      = last_q;
        fifo_pop    = 1'b0;
        timeout_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (can_issue) begin
                    fifo_pop    = 1'b1;
                    cmd_data_d  = fifo_rdata;
                    cmd_valid_d = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cmd_ready) begin
                    last_d = cmd_data_q;
                    if (can_issue) begin
                        fifo_pop   = 1'b1;
                        cmd_data_d = fifo_rdata;
                    end else begin
                        cmd_valid_d = 1'b0;
                        state_d     = S_IDLE;
                    end
                end
`ifdef HPS_CMD_SEQ_TIMEOUT_EN
                else if (tmo_hit) begin
                    cmd_valid_d = 1'b0;
                    timeout_set = 1'b1;
                    state_d     = S_IDLE;
                end
`endif
            end
            default: begin
                cmd_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // Sticky set wins over a same-cycle write-1-to-clear.
    assign ovf_d = (cmd_wr && fifo_full && !fifo_pop && !flush) ||
                   (ovf_q && !(status_wr && writedata[ST_OVF]));

    assign enable_d = ctrl_wr ? writedata[CTRL_ENABLE] : enable_q;
    assign irq_en_d = ctrl_wr ? writedata[CTRL_IRQ_EN] : irq_en_q;

    always_comb begin
        readdata_d = readdata_q;
        if (read) begin
            case (address)
                ADDR_STATUS: readdata_d = pack_status(cmd_valid_q, fifo_full, fifo_empty,
                                                      ovf_q, timeout_q, count5);
                ADDR_CTRL:   readdata_d = {29'd0, irq_en_q, 1'b0, enable_q};
                ADDR_LAST:   readdata_d = last_q;
                default:     readdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cmd_valid_q <= 1'b0;
            cmd_data_q  <= '0;
            last_q      <= '0;
            readdata_q  <= '0;
            enable_q    <= 1'b0;
            irq_en_q    <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_data_q  <= cmd_data_d;
            last_q      <= last_d;
            readdata_q  <= readdata_d;
            enable_q    <= enable_d;
            irq_en_q    <= irq_en_d;
            ovf_q       <= ovf_d;
        end
    end

    assign cmd_valid   = cmd_valid_q;
    assign cmd_data    = cmd_data_q;
    assign readdata    = readdata_q;
    assign irq         = irq_en_q && (ovf_q || timeout_q);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_hps_cmd_sequencer.sv
// Directed bench for hps_cmd_sequencer: register map, issue latency,
// overflow, stall/flow control, flush and the handshake watchdog.
module tb_hps_cmd_sequencer;

    localparam logic [1:0] A_CMD    = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_CTRL   = 2'd2;
    localparam logic [1:0] A_LAST   = 2'd3;

    logic        clock;
    logic        reset_n;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    logic [31:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        irq;
    logic [0:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    hps_cmd_sequencer #(
        .DEPTH          (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .address     (address),
        .write       (write),
        .writedata   (writedata),
        .read        (read),
        .readdata    (readdata),
        .cmd_data    (cmd_data),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .irq         (irq),
        .dbg_state_o (dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drivers are entered and left just after a falling edge.
    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        @(negedge clock);
        write     = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        read    = 1'b1;
        @(negedge clock);
        read    = 1'b0;
        d       = readdata;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", cmd_valid); end
        n_cmp++; if (cmd_data !== 32'h0) begin n_err++; $display("FAIL reset_data got %08h want 0", cmd_data); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got %0b want 0", irq); end
        n_cmp++; if (readdata !== 32'h0) begin n_err++; $display("FAIL reset_readdata got %08h want 0", readdata); end
        n_cmp++; if (dbg_state !== 1'b0) begin n_err++; $display("FAIL reset_state got %0b want 0", dbg_state); end
        bus_rd(A_STATUS, r);
        n_cmp++; if (r !== 32'h0000_0004) begin n_err++; $display("FAIL reset_status got %08h want 00000004", r); end
        bus_rd(A_CTRL, r);
        n_cmp++; if (r !== 32'h0) begin n_err++; $display("FAIL reset_ctrl got %08h want 0", r); end
    endtask

    task automatic test_single_issue();
        logic [31:0] r;
        cmd_ready = 1'b1;
        bus_wr(A_CTRL, 32'h1);
        bus_wr(A_CMD, 32'hDEAD_BEEF);
        n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL single_early got valid %0b want 0", cmd_valid); end
        @(negedge clock);
        n_cmp++; if (cmd_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %0b want 1", cmd_valid); end
        n_cmp++; if (cmd_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL single_data got %08h want deadbeef", cmd_data); end
        @(negedge clock);
        n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL single_drop got %0b want 0", cmd_valid); end
        bus_rd(A_LAST, r);
        n_cmp++; if (r !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL single_last got %08h want deadbeef", r); end
    endtask

    task automatic test_overflow();
        logic [31:0] r;
        bus_wr(A_CTRL, 32'h0);
        for (int i = 0; i < 5; i++) bus_wr(A_CMD, 32'h11 + i);
        bus_rd(A_STATUS, r);
        n_cmp++; if (r !== 32'h0000_040A) begin n_err++; $display("FAIL ovf_status got %08h want 0000040a", r); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL ovf_irq_masked got %0b want 0", irq); end
        bus_wr(A_CTRL, 32'h4);
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL ovf_irq got %0b want 1", irq); end
        bus_wr(A_STATUS, 32'h8);
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL ovf_irq_clr got %0b want 0", irq); end
        bus_rd(A_STATUS, r);
        n_cmp++; if (r !== 32'h0000_0402) begin n_err++; $display("FAIL ovf_cleared got %08h want 00000402", r); end
        cmd_ready = 1'b1;
        bus_wr(A_CTRL, 32'h1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            n_cmp++;
            if (cmd_valid !== 1'b1 || cmd_data !== 32'h11 + i) begin
                n_err++;
                $display("FAIL b2b_word%0d got v=%0b d=%08h want v=1 d=%08h", i, cmd_valid, cmd_data, 32'h11 + i);
            end
        end
        @(negedge clock);
        n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end got %0b want 0", cmd_valid); end
        bus_rd(A_LAST, r);
        n_cmp++; if (r !== 32'h14) begin n_err++; $display("FAIL b2b_last got %08h want 00000014", r); end
        bus_rd(A_STATUS, r);
        n_cmp++; if (r !== 32'h4) begin n_err++; $display("FAIL b2b_status got %08h want 00000004", r); end
    endtask

    task automatic test_stall();
        logic [2:0]  pat;
        logic        stalled;
        logic [31:0] held;
        int          got;
        pat     = 3'b101;
        stalled = 1'b0;
        held    = '0;
        got     = 0;
        bus_wr(A_CTRL, 32'h0);
        cmd_ready = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            bus_wr(A_CMD, 32'hA0 + i);
            exp_q.push_back(32'hA0 + i);
        end
        bus_wr(A_CTRL, 32'h1);
        for (int i = 0; i < 14; i++) begin
            cmd_ready = pat[i % 3];
            if (stalled && cmd_valid) begin
                n_cmp++;
                if (cmd_data !== held) begin n_err++; $display("FAIL stall_hold got %08h want %08h", cmd_data, held); end
            end
            if (cmd_valid && cmd_ready) begin
                got++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL stall_extra got %08h want none", cmd_data);
                end else begin
                    held = exp_q.pop_front();
                    if (cmd_data !== held) begin n_err++; $display("FAIL stall_order got %08h want %08h", cmd_data, held); end
                end
            end
            stalled = cmd_valid && !cmd_ready;
            held    = cmd_data;
            @(negedge clock);
        end
        n_cmp++; if (got !== 3) begin n_err++; $display("FAIL stall_count got %0d want 3", got); end
        n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL stall_end got %0b want 0", cmd_valid); end
    endtask

    task automatic test_flush();
        logic [31:0] r;
        bus_wr(A_CTRL, 32'h0);
        cmd_ready = 1'b0;
        bus_wr(A_CMD, 32'hF0);
        bus_wr(A_CMD, 32'hF1);
        bus_wr(A_CMD, 32'hF2);
        bus_wr(A_CTRL, 32'h1);
        @(negedge clock);
        bus_wr(A_CTRL, 32'h3);
        bus_rd(A_STATUS, r);
        n_cmp++; if (r !== 32'h5) begin n_err++; $display("FAIL flush_status got %08h want 00000005", r); end
        n_cmp++; if (cmd_valid !== 1'b1 || cmd_data !== 32'hF0) begin n_err++; $display("FAIL flush_inflight got v=%0b d=%08h want v=1 d=000000f0", cmd_valid, cmd_data); end
        cmd_ready = 1'b1;
        @(negedge clock);
        n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL flush_done got %0b want 0", cmd_valid); end
        repeat (3) @(negedge clock);
        n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_issue got %0b want 0", cmd_valid); end
        bus_rd(A_LAST, r);
        n_cmp++; if (r !== 32'hF0) begin n_err++; $display("FAIL flush_last got %08h want 000000f0", r); end
        bus_rd(A_CTRL, r);
        n_cmp++; if (r !== 32'h1) begin n_err++; $display("FAIL flush_ctrl got %08h want 00000001", r); end
    endtask

    task automatic test_timeout();
        logic [31:0] r;
        int          hi;
        hi = 0;
        cmd_ready = 1'b0;
        bus_wr(A_CTRL, 32'h5);
        bus_wr(A_CMD, 32'h7777_0001);
`ifdef HPS_CMD_SEQ_TIMEOUT_EN
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (cmd_valid) hi++;
        end
        n_cmp++; if (hi !== 8) begin n_err++; $display("FAIL tmo_cycles got %0d want 8", hi); end
        bus_rd(A_STATUS, r);
        n_cmp++; if (r !== 32'h14) begin n_err++; $display("FAIL tmo_status got %08h want 00000014", r); end
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL tmo_irq got %0b want 1", irq); end
        bus_rd(A_LAST, r);
        n_cmp++; if (r !== 32'hF0) begin n_err++; $display("FAIL tmo_last got %08h want 000000f0", r); end
        bus_wr(A_STATUS, 32'h10);
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL tmo_irq_clr got %0b want 0", irq); end
`else
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (cmd_valid) hi++;
        end
        n_cmp++; if (hi !== 20) begin n_err++; $display("FAIL hold_cycles got %0d want 20", hi); end
        bus_rd(A_STATUS, r);
        n_cmp++; if (r !== 32'h5) begin n_err++; $display("FAIL hold_status got %08h want 00000005", r); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL hold_irq got %0b want 0", irq); end
        cmd_ready = 1'b1;
        repeat (2) @(negedge clock);
        n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL hold_drain got %0b want 0", cmd_valid); end
        bus_rd(A_LAST, r);
        n_cmp++; if (r !== 32'h7777_0001) begin n_err++; $display("FAIL hold_last got %08h want 77770001", r); end
`endif
    endtask

    initial begin
        reset_n   = 1'b0;
        address   = '0;
        write     = 1'b0;
        writedata = '0;
        read      = 1'b0;
        cmd_ready = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        test_reset();
        test_single_issue();
        test_overflow();
        test_stall();
        test_flush();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hps_cmd_sequencer.md
# hps_cmd_sequencer

Avalon-MM slave controller that accepts 32-bit command words from the HPS, buffers them in a small FIFO, and issues them one at a time to the FPGA datapath over a valid/ready handshake. It replaces raw writedata passthrough wherever the downstream logic cannot accept a word on every HPS write. It adds flow control, overflow detection, a status/control register bank, and an interrupt. It sits between the HPS-to-FPGA bridge and the consuming datapath.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..16.
- TIMEOUT_CYCLES, 1024: handshake watchdog limit; used only with the macro in Configuration.
- clock  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  Avalon word address.
- write  in  1  Avalon write strobe.
- writedata  in  32  Avalon write data.
- read  in  1  Avalon read strobe.
- readdata  out  32  registered read data.
- cmd_data  out  32  command word to the datapath.
- cmd_valid  out  1  cmd_data is valid.
- cmd_ready  in  1  datapath accepts cmd_data.
- irq  out  1  level interrupt.

## Operation
- Register map:
  - addr 0 CMD (write only): pushes writedata into the FIFO.
  - addr 1 STATUS (read): [0] busy (cmd_valid), [1] full, [2] empty, [3] overflow sticky, [4] timeout sticky, [12:8] count. Writing 1 to bit 3 or bit 4 clears that bit.
  - addr 2 CTRL (read/write): [0] enable, [1] flush (self-clearing, reads 0), [2] irq_en.
  - addr 3 LAST (read): last word accepted by the datapath.
  - Unused bits read 0.
- Push: a CMD write with the FIFO full at cycle start is dropped and sets overflow. Exception: if a pop happens in the same cycle, the push is accepted.
- FSM states:
  - IDLE: enters ISSUE when enable=1 and the FIFO is non-empty; pops the head into cmd_data and sets cmd_valid.
  - ISSUE: cmd_data is held stable while cmd_valid=1 and cmd_ready=0. When cmd_ready=1, LAST is updated. If enable=1 and the FIFO is non-empty, the next word is popped in the same cycle and the FSM stays in ISSUE. Otherwise it clears cmd_valid and returns to IDLE.
- Flush: empties the FIFO in one cycle. An in-flight command is not aborted. Flush and push in the same cycle: the flush wins and the pushed word is discarded.
- Clearing enable while in ISSUE: the current handshake completes and no further pops occur.
- irq = irq_en & (overflow | timeout).
- Reset values: cmd_valid=0, cmd_data=0, readdata=0, irq=0, CTRL=0, stickies=0, LAST=0, FIFO empty, state IDLE.

## Timing
- Write-to-issue latency: for a CMD write sampled at edge t, with the FSM in IDLE, enable=1 and the FIFO empty, cmd_valid rises after edge t+1.
- Throughput: one command per clock while cmd_ready is held high and the FIFO is non-empty.
- Read latency: readdata is valid one cycle after read is sampled. There is no waitrequest; reads and writes are always accepted.
- STATUS reflects state after the previous edge. A same-cycle write and clear of a sticky bit: set wins.
- Pointer wrap-around uses log2(DEPTH) bits plus one extra bit; count ranges 0..DEPTH.

## Configuration
- HPS_CMD_SEQ_TIMEOUT_EN defined:
  - A counter runs while in ISSUE with cmd_ready=0 and resets on every handshake.
  - When it reaches TIMEOUT_CYCLES-1, cmd_valid drops, the word is discarded (LAST is not updated), timeout is set, and the FSM returns to IDLE.
- Undefined: no counter; cmd_valid is held indefinitely; STATUS[4] reads 0.

## Structure
- Package hps_cmd_pkg holds:
  - Register address constants (ADDR_CMD, ADDR_STATUS, ADDR_CTRL, ADDR_LAST).
  - STATUS and CTRL bit indices.
  - The FSM state encoding (S_IDLE, S_ISSUE).
- One sub-module, hps_cmd_fifo: synchronous FIFO parameterised by DEPTH and width, with push, pop, flush, full, empty and count. It shares the same clock and reset_n.

## Test plan
- Reset, then read STATUS -> 0x0000_0004 (empty only); cmd_valid=0; irq=0.
- CTRL=0x1, write CMD 0xDEAD_BEEF with cmd_ready=1 -> cmd_valid high for exactly one cycle after edge t+1, cmd_data=0xDEAD_BEEF; LAST reads 0xDEAD_BEEF.
- CTRL=0x0, write five CMDs with DEPTH=4 -> STATUS full=1, overflow=1, count=4. Write 1 to STATUS bit 3 -> overflow clears. Set enable with cmd_ready=1 -> the first four words issue back-to-back in order.
- cmd_ready toggles 1/0/1 with three words queued -> cmd_data stable while stalled; no word lost or duplicated.
- Mid-stall flush with two words queued -> in-flight word still completes, FIFO empty, no further issue.
- With HPS_CMD_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, CTRL=0x5, cmd_ready=0 -> cmd_valid drops after 8 cycles, STATUS bit 4=1, irq=1.
